// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8-bit UART receiver with a 1-entry AXI-stream holding register.
//            Optional even-parity framing when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full_m1 = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    localparam logic [2:0] c_idle      = 3'd0;
    localparam logic [2:0] c_start     = 3'd1;
    localparam logic [2:0] c_data      = 3'd2;
    localparam logic [2:0] c_stop      = 3'd3;
    localparam logic [2:0] c_wait_idle = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_parity    = 3'd5;
`endif

    logic [1:0]         r_sync;
    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_overrun;

    logic               w_rx_s;
    logic [2:0]         w_state_nx;
    logic [c_cnt_w-1:0] w_cnt_nx;
    logic [7:0]         w_shift_nx;
    logic [2:0]         w_bit_nx;
    logic               w_accept;
    logic               w_ferr;
`ifdef UART_RX_PARITY_EN
    logic               r_par_err;
    logic               w_par_err_nx;
`endif

    assign w_rx_s = r_sync[1];

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_shift_nx = r_shift;
        w_bit_nx   = r_bit;
        w_accept   = 1'b0;
        w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_err_nx = r_par_err;
`endif
        if (clk_en) begin
            case (r_state)
                c_idle: begin
                    if (!w_rx_s) begin
                        w_state_nx = c_start;
                        w_cnt_nx   = '0;
                    end
                end
                c_start: begin
                    // Mid-start-bit check rejects glitches shorter than half a bit.
                    if (r_cnt == c_half_m1) begin
                        w_cnt_nx   = '0;
                        w_bit_nx   = 3'd0;
                        w_state_nx = w_rx_s ? c_idle : c_data;
`ifdef UART_RX_PARITY_EN
                        w_par_err_nx = 1'b0;
`endif
                    end else begin
                        w_cnt_nx = r_cnt + c_one;
                    end
                end
                c_data: begin
                    if (r_cnt == c_full_m1) begin
                        w_cnt_nx   = '0;
                        w_shift_nx = {w_rx_s, r_shift[7:1]};
                        w_bit_nx   = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nx = c_parity;
`else
                            w_state_nx = c_stop;
`endif
                        end
                    end else begin
                        w_cnt_nx = r_cnt + c_one;
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_parity: begin
                    if (r_cnt == c_full_m1) begin
                        w_cnt_nx     = '0;
                        w_par_err_nx = (w_rx_s != (^r_shift));
                        w_ferr       = w_par_err_nx;
                        w_state_nx   = c_stop;
                    end else begin
                        w_cnt_nx = r_cnt + c_one;
                    end
                end
`endif
                c_stop: begin
                    if (r_cnt == c_full_m1) begin
                        w_cnt_nx = '0;
                        if (w_rx_s) begin
                            w_state_nx = c_idle;
`ifdef UART_RX_PARITY_EN
                            w_accept   = !r_par_err;
`else
                            w_accept   = 1'b1;
`endif
                        end else begin
                            w_ferr     = 1'b1;
                            w_state_nx = c_wait_idle;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + c_one;
                    end
                end
                c_wait_idle: begin
                    if (w_rx_s) w_state_nx = c_idle;
                end
                default: w_state_nx = c_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_state <= c_idle;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            if (clk_en) r_sync <= {r_sync[0], i_rx};
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_shift <= w_shift_nx;
            r_bit   <= w_bit_nx;
`ifdef UART_RX_PARITY_EN
            r_par_err <= w_par_err_nx;
`endif
        end
    end

    // Holding register: handshake runs every clk, a same-clk handshake frees the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (r_valid && i_ready) r_valid <= 1'b0;
            if (w_accept) begin
                if (!r_valid || i_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx; frame-level scoreboard model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LAT_LO = (NBITS - 1) * CPB + CPB / 2;
    localparam int LAT_HI = LAT_LO + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b1;
    logic       i_rx = 1'b1;
    logic       i_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         lat_q[$];
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    int         rx_seen = 0;
    int         ferr_seen = 0;
    int         ovr_seen = 0;
    logic [7:0] last_rx = 8'h00;
    logic       prev_valid = 1'b0;
    int         lat_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Outcome of each frame is decided from its bits and the ready level before it is sent.
    task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit par_flip,
                              input int low_extra);
        bit par_bad;
        bit good;
`ifdef UART_RX_PARITY_EN
        par_bad = par_flip;
`else
        par_bad = 1'b0;
`endif
        good = stop_v && !par_bad;
        if (par_bad) exp_ferr++;
        if (!stop_v) exp_ferr++;
        if (good) begin
            if (!i_ready && exp_q.size() > 0) exp_ovr++;
            else begin
                exp_q.push_back(b);
                if (i_ready) lat_q.push_back(cyc);
            end
        end
        i_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = (^b) ^ par_flip;
        tick(CPB);
`endif
        i_rx = stop_v;
        tick(CPB);
        if (low_extra > 0) begin
            i_rx = 1'b0;
            tick(low_extra);
        end
        i_rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) fail("rx_data", $sformatf("unexpected byte 0x%0h", o_data));
                else begin
                    check("rx_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
                    last_rx = o_data;
                    rx_seen++;
                    if (!prev_valid && lat_q.size() > 0) begin
                        lat_v = cyc - lat_q.pop_front();
                        n_cmp++;
                        if (lat_v < LAT_LO || lat_v > LAT_HI) begin
                            n_bad++;
                            $display("FAIL latency: got %0d clk, expected %0d..%0d", lat_v, LAT_LO, LAT_HI);
                        end
                    end
                end
            end else if (o_valid) begin
                if (exp_q.size() == 0) fail("held_data", $sformatf("unexpected byte 0x%0h", o_data));
                else check("held_data", {24'd0, o_data}, {24'd0, exp_q[0]});
            end
            if (o_frame_err) begin
                ferr_seen++;
                if (exp_ferr > 0) begin
                    exp_ferr--;
                    n_cmp++;
                end else fail("frame_err", "pulse with no bad frame outstanding");
            end
            if (o_overrun) begin
                ovr_seen++;
                if (exp_ovr > 0) begin
                    exp_ovr--;
                    n_cmp++;
                end else fail("overrun", "pulse with no dropped byte outstanding");
            end
        end
        prev_valid = o_valid;
    end

    int base_rx, base_fe, base_ov, gap;
    bit sv, pf;

    initial begin
        tick(5);
        rst = 1'b0;
        tick(2);
        check("reset_data", {24'd0, o_data}, 32'h00);
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_ferr", {31'd0, o_frame_err}, 32'd0);
        check("reset_ovr", {31'd0, o_overrun}, 32'd0);

        // Single byte, consumer ready.
        base_rx = rx_seen; base_fe = ferr_seen;
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        tick(20);
        check("a5_byte", {24'd0, last_rx}, 32'hA5);
        check("a5_count", rx_seen - base_rx, 32'd1);
        check("a5_noerr", ferr_seen - base_fe, 32'd0);

        // Back-to-back with consumer stalled: second byte dropped.
        i_ready = 1'b0;
        base_rx = rx_seen; base_ov = ovr_seen;
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        send_frame(8'h81, 1'b1, 1'b0, 0);
        tick(20);
        check("ovr_count", ovr_seen - base_ov, 32'd1);
        check("ovr_valid", {31'd0, o_valid}, 32'd1);
        check("ovr_held", {24'd0, o_data}, 32'h3C);
        i_ready = 1'b1;
        tick(15);
        check("ovr_byte", {24'd0, last_rx}, 32'h3C);
        check("ovr_only", rx_seen - base_rx, 32'd1);

        // Bad stop bit, line held low, then recovery.
        base_fe = ferr_seen; base_rx = rx_seen;
        send_frame(8'h55, 1'b0, 1'b0, 20);
        tick(8);
        check("fe_count", ferr_seen - base_fe, 32'd1);
        check("fe_novalid", rx_seen - base_rx, 32'd0);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        tick(20);
        check("fe_recover", {24'd0, last_rx}, 32'h12);

        // One-clk glitch on an idle line.
        base_rx = rx_seen; base_fe = ferr_seen;
        i_rx = 1'b0; tick(1); i_rx = 1'b1;
        tick(20);
        check("glitch_rx", rx_seen - base_rx, 32'd0);
        check("glitch_fe", ferr_seen - base_fe, 32'd0);

        // Reset in the middle of bit 4 of 0xFF.
        base_rx = rx_seen;
        i_rx = 1'b0; tick(CPB);
        i_rx = 1'b1; tick(4 * CPB + CPB / 2);
        rst = 1'b1; tick(1); rst = 1'b0;
        check("rst_data", {24'd0, o_data}, 32'h00);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        tick((NBITS - 5) * CPB);
        tick(10);
        send_frame(8'h0F, 1'b1, 1'b0, 0);
        tick(20);
        check("rst_byte", {24'd0, last_rx}, 32'h0F);
        check("rst_count", rx_seen - base_rx, 32'd1);

`ifdef UART_RX_PARITY_EN
        base_fe = ferr_seen; base_rx = rx_seen;
        send_frame(8'h07, 1'b1, 1'b1, 0);
        tick(10);
        check("par_err", ferr_seen - base_fe, 32'd1);
        send_frame(8'h07, 1'b1, 1'b0, 0);
        tick(20);
        check("par_ok", {24'd0, last_rx}, 32'h07);
        check("par_count", rx_seen - base_rx, 32'd1);
`endif

        // Randomized traffic, consumer ready.
        for (int k = 0; k < 60; k++) begin
            sv = ($urandom_range(0, 9) != 0);
`ifdef UART_RX_PARITY_EN
            pf = ($urandom_range(0, 9) == 0);
`else
            pf = 1'b0;
`endif
            send_frame(8'($urandom_range(0, 255)), sv, pf, 0);
            gap = (!sv) ? 4 + $urandom_range(0, 6) : $urandom_range(0, 6);
            tick(gap);
            if ($urandom_range(0, 7) == 0) begin
                i_rx = 1'b0; tick(1); i_rx = 1'b1;
                tick(6);
            end
        end
        tick(20);

        // Randomized stalls: bursts while not ready.
        for (int k = 0; k < 6; k++) begin
            i_ready = 1'b0;
            for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 0);
            tick(15);
            i_ready = 1'b1;
            tick(10);
        end

        tick(30);
        check("end_bytes_left", exp_q.size(), 32'd0);
        check("end_ferr_left", exp_ferr, 32'd0);
        check("end_ovr_left", exp_ovr, 32'd0);
        check("end_lat_left", lat_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
